bus_read_sequencer: RTL and testbench

- Sequences one peripheral read at a time on the MCU peripheral bus.
- Decodes the slave index from the request address and drives the select/enable inputs of the 8-way read-data bus multiplexer.
- Strobes the addressed slave, waits for its ready (bounded by a timeout), then captures the multiplexer output into a registered read-data word.
- Position: between the core's load path (upstream) and the 8-input peripheral read-data multiplexer. The block feeds the multiplexer and consumes its output.

---
 rtl/bus_read_sequencer_if.sv | 25 ++
 rtl/bus_read_sequencer.sv | 52 +++++
 tb/tb_bus_read_sequencer.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/bus_read_sequencer_if.sv
// bus_read_sequencer_if: load-path request, per-slave ready and read-data multiplexer signals.
interface bus_read_sequencer_if #(
  parameter int NrOfBits = 32,
  parameter int AddrBits = 32
);
  logic                Req;
  logic [AddrBits-1:0] Addr;
  logic [7:0]          Ready;
  logic [NrOfBits-1:0] MuxData;
  logic [2:0]          MuxSel;
  logic                MuxEnable;
  logic [7:0]          SlaveStrobe;
  logic                Busy;
  logic                Done;
  logic                Error;
  logic [NrOfBits-1:0] RdData;
  modport master (
    input  Req, Addr, Ready, MuxData,
    output MuxSel, MuxEnable, SlaveStrobe, Busy, Done, Error, RdData
  );
  modport slave (
    output Req, Addr, Ready, MuxData,
    input  MuxSel, MuxEnable, SlaveStrobe, Busy, Done, Error, RdData
  );
endinterface

// File: rtl/bus_read_sequencer.sv
// bus_read_sequencer: one peripheral read at a time with a ready timeout.
module bus_read_sequencer #(
  parameter int NrOfBits      = 32,
  parameter int AddrBits      = 32,
  parameter int SelLsb        = 12,
  parameter int TimeoutCycles = 16
) (
  input logic                   Clock,
  input logic                   Reset_n,
  bus_read_sequencer_if.master  bus
);
  typedef enum logic {sIdle, sWait} stateType;
  localparam logic [7:0] LastCount = 8'(TimeoutCycles - 1);
  stateType   state;
  logic [7:0] count;
  logic       hit;
  assign hit = bus.Ready[bus.MuxSel];
  // MuxSel doubles as the latched slave index for the whole access.
  always_ff @(posedge Clock or negedge Reset_n)
    if (!Reset_n) begin
      state           <= sIdle;
      count           <= '0;
      bus.MuxSel      <= '0;
      bus.MuxEnable   <= 1'b0;
      bus.SlaveStrobe <= '0;
      bus.Busy        <= 1'b0;
      bus.Done        <= 1'b0;
      bus.Error       <= 1'b0;
      bus.RdData      <= '0;
    end else begin
      bus.Done <= 1'b0;
      if (state == sIdle) begin
        if (bus.Req) begin
          state           <= sWait;
          count           <= '0;
          bus.MuxSel      <= bus.Addr[SelLsb+2:SelLsb];
          bus.MuxEnable   <= 1'b1;
          bus.SlaveStrobe <= 8'b1 << bus.Addr[SelLsb+2:SelLsb];
          bus.Busy        <= 1'b1;
        end
      end else if (hit || count == LastCount) begin
        state           <= sIdle;
        bus.MuxEnable   <= 1'b0;
        bus.SlaveStrobe <= '0;
        bus.Busy        <= 1'b0;
        bus.Done        <= 1'b1;
        bus.Error       <= !hit;
        bus.RdData      <= hit ? bus.MuxData : '0;
      end else
        count <= count + 8'd1;
    end
endmodule

// File: tb/tb_bus_read_sequencer.sv
// tb_bus_read_sequencer: random and directed reads checked by a queue-based scoreboard.
module tb_bus_read_sequencer;
  localparam int T = 16;
  localparam int Lsb = 12;
  logic Clock = 1'b0;
  logic Reset_n = 1'b1;
  always #5 Clock = ~Clock;
  bus_read_sequencer_if #(.NrOfBits(32), .AddrBits(32)) bus ();
  bus_read_sequencer #(.NrOfBits(32), .AddrBits(32), .SelLsb(Lsb), .TimeoutCycles(T)) dut (
    .Clock(Clock), .Reset_n(Reset_n), .bus(bus)
  );
  logic [31:0] memData [8];
  assign bus.MuxData = bus.MuxEnable ? memData[bus.MuxSel] : 32'h0;
  typedef struct {
    int          c0;
    int          lat;
    logic [2:0]  sel;
    logic [31:0] data;
    logic        err;
  } expT;
  expT sb[$];
  int checks = 0;
  int failures = 0;
  int cyc = 0;
  logic [2:0]  lastSel = 3'd0;
  logic [31:0] lastData = 32'h0;
  logic        lastErr = 1'b0;
  bit          holdReq = 1'b0;
  always @(posedge Clock) cyc++;
  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cycle=%0d got=%h want=%h", name, cyc, act, exp);
    end
  endtask
  always @(negedge Clock)
    if (Reset_n) begin
      bit inWait;
      bit doneNow;
      inWait  = sb.size() > 0 && cyc > sb[0].c0 && cyc < sb[0].c0 + sb[0].lat;
      doneNow = sb.size() > 0 && cyc == sb[0].c0 + sb[0].lat;
      if (inWait) lastSel = sb[0].sel;
      chk("Busy", 32'(bus.Busy), 32'(inWait));
      chk("MuxEnable", 32'(bus.MuxEnable), 32'(inWait));
      chk("SlaveStrobe", 32'(bus.SlaveStrobe), inWait ? 32'(8'b1 << sb[0].sel) : 32'h0);
      chk("MuxSel", 32'(bus.MuxSel), 32'(lastSel));
      chk("Done", 32'(bus.Done), 32'(doneNow));
      if (doneNow) begin
        lastData = sb[0].data;
        lastErr  = sb[0].err;
        void'(sb.pop_front());
      end
      chk("RdData", bus.RdData, lastData);
      chk("Error", 32'(bus.Error), 32'(lastErr));
    end
  task automatic chkZero(string tag);
    chk({tag, " Busy"}, 32'(bus.Busy), 32'h0);
    chk({tag, " Done"}, 32'(bus.Done), 32'h0);
    chk({tag, " Error"}, 32'(bus.Error), 32'h0);
    chk({tag, " MuxSel"}, 32'(bus.MuxSel), 32'h0);
    chk({tag, " MuxEnable"}, 32'(bus.MuxEnable), 32'h0);
    chk({tag, " SlaveStrobe"}, 32'(bus.SlaveStrobe), 32'h0);
    chk({tag, " RdData"}, bus.RdData, 32'h0);
  endtask
  // Issues one read from the current negedge; Ready[sel] rises in WAIT cycle k (k>T: never).
  task automatic access(logic [31:0] addr, int k, logic [31:0] data);
    logic [2:0] s = addr[Lsb+2:Lsb];
    int n = k <= T ? k : T;
    foreach (memData[i]) memData[i] = $urandom;
    memData[s] = data;
    bus.Req  = 1'b1;
    bus.Addr = addr;
    sb.push_back(expT'{cyc, n + 1, s, k <= T ? data : 32'h0, k > T});
    for (int w = 1; w <= n; w++) begin
      @(negedge Clock);
      bus.Req   = holdReq ? 1'b1 : 1'($urandom);
      bus.Addr  = $urandom;
      bus.Ready = 8'($urandom);
      bus.Ready[s] = (w == k);
      foreach (memData[i]) if (i != int'(s)) memData[i] = $urandom;
    end
    @(negedge Clock);
    bus.Req   = 1'b0;
    bus.Ready = 8'($urandom);
  endtask
  function automatic logic [31:0] addrFor(logic [2:0] s);
    logic [31:0] a = $urandom;
    a[Lsb+2:Lsb] = s;
    return a;
  endfunction
  initial begin
    #500000;
    $display("FAIL watchdog cycle=%0d", cyc);
    $fatal(1);
  end
  initial begin
    bus.Req = 1'b0;
    bus.Addr = 32'h0;
    bus.Ready = 8'h0;
    foreach (memData[i]) memData[i] = 32'h0;
    #1 Reset_n = 1'b0;
    #1 chkZero("reset");
    repeat (2) @(negedge Clock);
    Reset_n = 1'b1;
    repeat (2) @(negedge Clock);
    access(32'h0000_3000, 1, 32'hDEADBEEF);
    @(negedge Clock);
    access(addrFor(3'd7), 4, $urandom);
    repeat (2) @(negedge Clock);
    access(addrFor(3'd2), T + 1, $urandom);
    access(addrFor(3'd2), T, $urandom);
    @(negedge Clock);
    holdReq = 1'b1;
    for (int i = 0; i < 8; i++) access(addrFor(i % 2 ? 3'd6 : 3'd1), 1, $urandom);
    holdReq = 1'b0;
    repeat (2) @(negedge Clock);
    for (int i = 0; i < 40; i++) begin
      access($urandom, $urandom_range(1, T + 1), $urandom);
      repeat ($urandom_range(0, 2)) @(negedge Clock);
    end
    bus.Req  = 1'b1;
    bus.Addr = addrFor(3'd5);
    sb.push_back(expT'{cyc, T + 1, 3'd5, 32'h0, 1'b1});
    @(negedge Clock);
    bus.Req   = 1'b0;
    bus.Ready = 8'h0;
    @(negedge Clock);
    #2 Reset_n = 1'b0;
    sb.delete();
    lastSel  = 3'd0;
    lastData = 32'h0;
    lastErr  = 1'b0;
    #1 chkZero("midreset");
    @(negedge Clock);
    #2 Reset_n = 1'b1;
    repeat (4) @(negedge Clock);
    access(addrFor(3'd4), 2, 32'h1234_5678);
    repeat (3) @(negedge Clock);
    chk("pending", sb.size(), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
